// File: rtl/pattern_tx_if.sv
// rtl/pattern_tx_if.sv - request/stream signal bundle between a pattern source and pattern_tx
`timescale 1ns/1ps
interface pattern_tx_if #(
    parameter int PAT_WIDTH = 4,
    parameter int CNT_WIDTH = 4
) ();
    logic                 start;
    logic [PAT_WIDTH-1:0] pattern;
    logic [CNT_WIDTH-1:0] repeat_cnt;
    logic                 o;
    logic                 busy;
    logic                 done;

    modport master (
        output start, pattern, repeat_cnt,
        input  o, busy, done
    );

    modport slave (
        input  start, pattern, repeat_cnt,
        output o, busy, done
    );
endinterface

// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - serial MSB-first pattern transmitter with repeat count and done pulse
`timescale 1ns/1ps
module pattern_tx #(
    parameter int PAT_WIDTH = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    pattern_tx_if.slave bus
);
    localparam int IDX_W = $clog2(PAT_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state_q, state_d;
    logic [PAT_WIDTH-1:0] pat_q, pat_d;
    logic [CNT_WIDTH-1:0] rep_q, rep_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 o_q, o_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Next-state and next-output logic; outputs are computed here and registered below
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        idx_d   = idx_q;
        o_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pat_d   = bus.pattern;
                    rep_d   = bus.repeat_cnt;
                    idx_d   = LAST_IDX;
                    o_d     = bus.pattern[PAT_WIDTH-1];
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (idx_q == '0) begin
                    if (rep_q != '0) begin
                        // Wrap straight into the next repetition with no gap
                        rep_d  = rep_q - 1'b1;
                        idx_d  = LAST_IDX;
                        o_d    = pat_q[PAT_WIDTH-1];
                        busy_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    idx_d  = idx_q - 1'b1;
                    o_d    = pat_q[idx_q - 1'b1];
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer immediately
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            rep_q   <= '0;
            idx_q   <= '0;
            o_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o    = o_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - self-checking bench for pattern_tx
`timescale 1ns/1ps
module tb_pattern_tx;
    logic clk;
    logic n_rst;
    int   checks;
    int   failures;

    pattern_tx_if #(.PAT_WIDTH(4), .CNT_WIDTH(4)) bus ();

    pattern_tx #(.PAT_WIDTH(4), .CNT_WIDTH(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  pat;
        logic [3:0]  rep;
        logic [63:0] stream;
        int          len;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " o"}, 64'(bus.o), 64'd0);
        chk({name, " busy"}, 64'(bus.busy), 64'd0);
        chk({name, " done"}, 64'(bus.done), 64'd0);
    endtask

    // Reference: the pattern repeated rep+1 times, MSB first, as a bit string
    task automatic model(input logic [3:0] pat, input logic [3:0] rep,
                         output logic [63:0] stream, output int len);
        stream = '0;
        len    = 0;
        for (int r = 0; r <= int'(rep); r++) begin
            for (int b = 3; b >= 0; b--) begin
                stream = {stream[62:0], pat[b]};
                len++;
            end
        end
    endtask

    // Issue one start pulse and check every bit, busy and the done pulse
    task automatic run_transfer(input string name, input logic [3:0] pat, input logic [3:0] rep,
                                input logic [63:0] stream, input int len);
        @(posedge clk);
        #0.1;
        bus.start      = 1'b1;
        bus.pattern    = pat;
        bus.repeat_cnt = rep;
        @(posedge clk);
        #0.1;
        bus.start      = 1'b0;
        bus.pattern    = 4'($urandom);
        bus.repeat_cnt = 4'($urandom);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            chk($sformatf("%s bit%0d o", name, i), 64'(bus.o), 64'(stream[len-1-i]));
            chk($sformatf("%s bit%0d busy", name, i), 64'(bus.busy), 64'd1);
            chk($sformatf("%s bit%0d done", name, i), 64'(bus.done), 64'd0);
        end
        @(negedge clk);
        chk({name, " done pulse"}, 64'(bus.done), 64'd1);
        chk({name, " busy at done"}, 64'(bus.busy), 64'd0);
        chk({name, " o at done"}, 64'(bus.o), 64'd0);
        @(negedge clk);
        chk_idle({name, " after done"});
    endtask

    vec_t        vecs[6];
    logic [63:0] st;
    int          ln;
    logic [3:0]  rp, rr;
    logic [5:0]  held_bits;

    initial begin
        checks   = 0;
        failures = 0;
        bus.start      = 1'b0;
        bus.pattern    = '0;
        bus.repeat_cnt = '0;
        n_rst          = 1'b1;

        vecs[0] = '{4'b1101, 4'd0,  64'b1101, 4};
        vecs[1] = '{4'b1101, 4'd1,  64'b1101_1101, 8};
        vecs[2] = '{4'b1011, 4'd2,  64'b1011_1011_1011, 12};
        vecs[3] = '{4'b0000, 4'd0,  64'b0000, 4};
        vecs[4] = '{4'b1000, 4'd3,  64'h8888, 16};
        vecs[5] = '{4'b1111, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 64};

        // Reset asserted mid-cycle takes effect without a clock edge
        #3;
        n_rst = 1'b0;
        #1;
        chk_idle("reset async");
        @(posedge clk);
        #0.8;
        n_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_idle($sformatf("post reset %0d", i));
        end

        for (int t = 0; t < 6; t++)
            run_transfer($sformatf("tbl%0d", t), vecs[t].pat, vecs[t].rep, vecs[t].stream, vecs[t].len);

        // Start while busy must be ignored
        @(posedge clk);
        #0.1;
        bus.start = 1'b1; bus.pattern = 4'b1101; bus.repeat_cnt = 4'd0;
        @(posedge clk);
        #0.1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy start bit0", 64'(bus.o), 64'd1);
        @(posedge clk);
        #0.1;
        bus.start = 1'b1; bus.pattern = 4'b0000; bus.repeat_cnt = 4'd5;
        @(negedge clk);
        chk("busy start bit1", 64'(bus.o), 64'd1);
        @(posedge clk);
        #0.1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy start bit2", 64'(bus.o), 64'd0);
        @(negedge clk);
        chk("busy start bit3", 64'(bus.o), 64'd1);
        @(negedge clk);
        chk("busy start done", 64'(bus.done), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("busy start dropped %0d", i));
        end

        // Held start: 6-cycle period, four bits then two idle cycles
        held_bits = 6'b1011_00;
        @(posedge clk);
        #0.1;
        bus.start = 1'b1; bus.pattern = 4'b1011; bus.repeat_cnt = 4'd0;
        @(posedge clk);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk($sformatf("held %0d o", i), 64'(bus.o), 64'(held_bits[5 - (i % 6)]));
            chk($sformatf("held %0d busy", i), 64'(bus.busy), 64'((i % 6) < 4));
            chk($sformatf("held %0d done", i), 64'(bus.done), 64'((i % 6) == 4));
        end
        // Drop start on the last idle cycle of the third period so no new transfer begins
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_idle($sformatf("held release %0d", i));
        end

        // Reset during the third bit abandons the transfer
        @(posedge clk);
        #0.1;
        bus.start = 1'b1; bus.pattern = 4'b1101; bus.repeat_cnt = 4'd3;
        @(posedge clk);
        #0.1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("rst mid bit0", 64'(bus.o), 64'd1);
        @(negedge clk);
        chk("rst mid bit1", 64'(bus.o), 64'd1);
        @(negedge clk);
        chk("rst mid bit2 busy", 64'(bus.busy), 64'd1);
        #1;
        n_rst = 1'b0;
        #0.1;
        chk_idle("rst mid async");
        @(posedge clk);
        #0.8;
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("rst mid after %0d", i));
        end
        run_transfer("rst mid fresh", 4'b1101, 4'd0, 64'b1101, 4);

        // Random transfers against the reference model
        for (int t = 0; t < 20; t++) begin
            rp = 4'($urandom);
            rr = 4'($urandom_range(0, 4));
            model(rp, rr, st, ln);
            run_transfer($sformatf("rnd%0d p=%0h r=%0d", t, rp, rr), rp, rr, st, ln);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pattern_tx.md
# pattern_tx

Serial bit-pattern transmitter: the driving end of the serial bit-stream interface that the Moore `1101` sequence detector consumes. On a start request it latches a PAT_WIDTH-bit pattern and a repeat count, then shifts the pattern out MSB-first, one bit per clock, on a registered serial output. It transmits the pattern (repeat_cnt + 1) times back-to-back, then pulses `done`. It sits directly in front of the detector, with `o` wired to the detector's `i`, and serves as a self-checking stimulus and loopback source.

## Interface
- PAT_WIDTH, 4: pattern length in bits; legal range 2..16.
- CNT_WIDTH, 4: width of the repeat-count input.
- clk  in  1  system clock; all state changes on the rising edge.
- n_rst  in  1  reset; asynchronous, active-low.
- start  in  1  transmit request; sampled on the rising edge.
- pattern  in  PAT_WIDTH  pattern to send; bit PAT_WIDTH-1 is sent first.
- repeat_cnt  in  CNT_WIDTH  extra repetitions; 0 means the pattern is sent once.
- o  out  1  serial data, registered.
- busy  out  1  high while bits are being shifted, registered.
- done  out  1  one-cycle completion pulse, registered.

## Operation
- FSM states are IDLE, SHIFT and DONE. The reset state is IDLE.
- IDLE behaviour:
  - Outputs are o=0, busy=0, done=0.
  - start=1 at a rising edge latches `pattern` into the shift register and `repeat_cnt` into the repeat counter.
  - On that same edge the bit index is set to PAT_WIDTH-1, o is set to pattern[PAT_WIDTH-1], busy is set to 1, and the FSM moves to SHIFT.
- SHIFT behaviour:
  - Each edge advances one bit.
  - When the bit index reaches 0 and the repeat counter is nonzero: decrement the repeat counter, reload the bit index to PAT_WIDTH-1, and drive the latched MSB next. There is no idle gap between repetitions.
  - When the bit index reaches 0 and the repeat counter is 0: go to DONE with o=0, busy=0, done=1.
- DONE behaviour: hold for exactly one cycle, then return to IDLE with done=0.
- start is ignored in SHIFT and DONE.
- The pattern and repeat_cnt inputs are don't-care except at the accepting edge; the latched copies are used for the whole transfer.
- If start is held high continuously, a new transfer begins at the first edge after the FSM returns to IDLE. This gives exactly two idle (o=0) cycles between transfers: the DONE cycle plus one IDLE cycle.
- Counter widths:
  - Bit index width is $clog2(PAT_WIDTH).
  - Repeat counter width is CNT_WIDTH.
  - The repeat counter never decrements below 0, so it cannot wrap.
- Total bits per transfer = PAT_WIDTH × (repeat_cnt + 1). With defaults the maximum is 4 × 16 = 64.
- Reset asserted at any time forces IDLE, o=0, busy=0, done=0 and clears the latched pattern and counters immediately, without waiting for a clock. A transfer interrupted by reset is abandoned, not resumed.

## Timing
- Latency from accepting edge (start=1) to first bit: the MSB appears on o immediately after that same edge. That is 0 cycles of latency as seen by a downstream flop sampling on the next edge.
- Each bit is held for exactly one clock period.
- done rises on the edge after the last bit's period ends. It stays high for 1 cycle, and busy falls on that same edge.
- busy is high for exactly PAT_WIDTH × (repeat_cnt + 1) cycles per transfer.
- All outputs are flop outputs; there are no combinational paths from inputs to outputs.
- Setup, hold and removal requirements match the team's standard cell library. The bench drives inputs 100 ps after the edge and releases n_rst 800 ps after the edge, per the team bench convention.

## Test plan
- Reset check: assert n_rst=0 mid-cycle → o=0, busy=0, done=0 before the next edge; all stay 0 for 2 cycles after release with start=0.
- Single transfer: pattern=4'b1101, repeat_cnt=0, start pulsed 1 cycle → o samples 1,1,0,1 on four consecutive edges; busy high 4 cycles; done high exactly on the 5th edge; o=0 afterwards. When looped into the detector, the detector output goes to 1.
- Repeat transfer: pattern=4'b1101, repeat_cnt=1 → o = 1,1,0,1,1,1,0,1 with no gap; busy high 8 cycles; exactly one done pulse; the looped detector output goes high at least twice.
- Start while busy: pulse start again at the 2nd bit with pattern=4'b0000 → the stream is unchanged (1,1,0,1) and the new request is dropped.
- Held start: start=1 constantly with pattern=4'b1011 → stream 1,0,1,1,0,0,1,0,1,1,…; done pulses every 6 cycles.
- Reset mid-transfer: drop n_rst during the 3rd bit → o=0 and busy=0 immediately. After release, o stays 0 until a new start; a fresh start with 4'b1101 transmits cleanly.
